// File: rtl/ov7670_pkg.sv
// Shared types and defaults for the OV7670 DVP capture path.
// The frame state is a plain 2-bit typedef so the constants stay usable in legacy code.
package ov7670_pkg;
  localparam int H_ACT_DEF = 640;
  localparam int V_ACT_DEF = 480;

  typedef logic [1:0] state_t;
  localparam state_t S_SYNC   = 2'd0;
  localparam state_t S_VBLANK = 2'd1;
  localparam state_t S_ACTIVE = 2'd2;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  function automatic int fb_addr_w(input int h, input int v);
    return $clog2(h * v);
  endfunction
endpackage

// File: rtl/cam_sync.sv
// Two-flop synchronizer for the DVP bus plus registered edge detection.
// Data rides the same stages as pclk, so o_d_s is aligned with o_pclk_rise.
module cam_sync (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pclk,
  input  logic       i_href,
  input  logic       i_vsync,
  input  logic [7:0] i_d,
  output logic       o_pclk_rise,
  output logic       o_href_s,
  output logic       o_href_fall,
  output logic       o_vsync_s,
  output logic       o_vsync_rise,
  output logic       o_vsync_fall,
  output logic [7:0] o_d_s
);
  logic [10:0] r_meta, r_sync;
  logic        r_pclk_q, r_href_q, r_vsync_q;
  logic        r_pclk_rise, r_href_s, r_href_fall, r_vsync_s, r_vsync_rise, r_vsync_fall;
  logic [7:0]  r_d_s;
  logic        w_pclk_s, w_href_s, w_vsync_s;
  logic [7:0]  w_d_s;

  assign {w_pclk_s, w_href_s, w_vsync_s, w_d_s} = r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_meta       <= '0;
      r_sync       <= '0;
      r_pclk_q     <= 1'b0;
      r_href_q     <= 1'b0;
      r_vsync_q    <= 1'b0;
      r_pclk_rise  <= 1'b0;
      r_href_s     <= 1'b0;
      r_href_fall  <= 1'b0;
      r_vsync_s    <= 1'b0;
      r_vsync_rise <= 1'b0;
      r_vsync_fall <= 1'b0;
      r_d_s        <= '0;
    end else begin
      r_meta       <= {i_pclk, i_href, i_vsync, i_d};
      r_sync       <= r_meta;
      r_pclk_q     <= w_pclk_s;
      r_href_q     <= w_href_s;
      r_vsync_q    <= w_vsync_s;
      r_pclk_rise  <= w_pclk_s & ~r_pclk_q;
      r_href_s     <= w_href_s;
      r_href_fall  <= ~w_href_s & r_href_q;
      r_vsync_s    <= w_vsync_s;
      r_vsync_rise <= w_vsync_s & ~r_vsync_q;
      r_vsync_fall <= ~w_vsync_s & r_vsync_q;
      r_d_s        <= w_d_s;
    end
  end

  assign o_pclk_rise  = r_pclk_rise;
  assign o_href_s     = r_href_s;
  assign o_href_fall  = r_href_fall;
  assign o_vsync_s    = r_vsync_s;
  assign o_vsync_rise = r_vsync_rise;
  assign o_vsync_fall = r_vsync_fall;
  assign o_d_s        = r_d_s;
endmodule

// File: rtl/ov7670_capture.sv
// OV7670 RGB444 capture: frame FSM, byte pairing and linear frame-buffer write generation.
// Optional DECIMATE_EN keeps only even rows/cols and packs them into a half-size buffer.
module ov7670_capture
  import ov7670_pkg::*;
#(
  parameter int H_ACT  = H_ACT_DEF,
  parameter int V_ACT  = V_ACT_DEF,
  parameter int ADDR_W = fb_addr_w(H_ACT, V_ACT)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cap_en,
  input  logic              i_cam_pclk,
  input  logic              i_cam_href,
  input  logic              i_cam_vsync,
  input  logic [7:0]        i_cam_d,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [11:0]       o_wr_data,
  output logic              o_frame_done,
  output logic              o_capturing
);
  localparam int CW = $clog2(H_ACT + 1);
  localparam int RW = $clog2(V_ACT + 1);
  localparam logic [CW-1:0] COL_MAX = CW'(H_ACT);
  localparam logic [RW-1:0] ROW_MAX = RW'(V_ACT);
`ifdef DECIMATE_EN
  localparam logic [ADDR_W-1:0] BASE_STEP = ADDR_W'(H_ACT / 2);
`else
  localparam logic [ADDR_W-1:0] BASE_STEP = ADDR_W'(H_ACT);
`endif

  logic              w_pclk_rise, w_href_s, w_href_fall, w_vsync_s, w_vsync_rise, w_vsync_fall;
  logic [7:0]        w_d_s;
  logic              w_in_win, w_keep, w_base_adv;
  logic [ADDR_W-1:0] w_addr;

  state_t            r_state;
  logic              r_arm, r_phase;
  logic [3:0]        r_hi;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [ADDR_W-1:0] r_base;
  logic              r_wr_en, r_frame_done;
  logic [ADDR_W-1:0] r_wr_addr;
  rgb444_t           r_pix;

  cam_sync u_sync (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_pclk       (i_cam_pclk),
    .i_href       (i_cam_href),
    .i_vsync      (i_cam_vsync),
    .i_d          (i_cam_d),
    .o_pclk_rise  (w_pclk_rise),
    .o_href_s     (w_href_s),
    .o_href_fall  (w_href_fall),
    .o_vsync_s    (w_vsync_s),
    .o_vsync_rise (w_vsync_rise),
    .o_vsync_fall (w_vsync_fall),
    .o_d_s        (w_d_s)
  );

  assign w_in_win = (r_col < COL_MAX) && (r_row < ROW_MAX);
`ifdef DECIMATE_EN
  assign w_keep     = ~r_row[0] & ~r_col[0];
  assign w_base_adv = ~r_row[0];
  assign w_addr     = r_base + ADDR_W'(r_col >> 1);
`else
  assign w_keep     = 1'b1;
  assign w_base_adv = 1'b1;
  assign w_addr     = r_base + ADDR_W'(r_col);
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= S_SYNC;
      r_arm        <= 1'b0;
      r_phase      <= 1'b0;
      r_hi         <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_base       <= '0;
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      r_wr_addr    <= '0;
      r_pix        <= '0;
    end else begin
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_SYNC: if (w_vsync_s) r_state <= S_VBLANK;
        S_VBLANK: if (w_vsync_fall) begin
          r_arm   <= i_cap_en;
          r_row   <= '0;
          r_col   <= '0;
          r_base  <= '0;
          r_phase <= 1'b0;
          r_state <= S_ACTIVE;
        end
        S_ACTIVE: begin
          // Frame close wins over a coincident byte; any half pixel is lost.
          if (w_vsync_rise) begin
            r_frame_done <= r_arm;
            r_state      <= S_VBLANK;
          end else if (w_href_fall) begin
            r_phase <= 1'b0;
            r_col   <= '0;
            if (r_row < ROW_MAX) begin
              r_row <= r_row + RW'(1);
              if (w_base_adv) r_base <= r_base + BASE_STEP;
            end
          end else if (w_href_s && w_pclk_rise) begin
            r_phase <= ~r_phase;
            if (!r_phase) begin
              r_hi <= w_d_s[3:0];
            end else begin
              if (r_arm && w_in_win && w_keep) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= w_addr;
                r_pix     <= rgb444_t'({r_hi, w_d_s});
              end
              if (r_col < COL_MAX) r_col <= r_col + CW'(1);
            end
          end
        end
        default: r_state <= S_SYNC;
      endcase
    end
  end

  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_pix;
  assign o_frame_done = r_frame_done;
  assign o_capturing  = r_arm && (r_state == S_ACTIVE);
endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture at H_ACT=4, V_ACT=4 with a small write-order model.
module tb_ov7670_capture;
  localparam int H = 4;
  localparam int V = 4;
  localparam int AW = 5;
`ifdef DECIMATE_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, cap_en, cam_pclk, cam_href, cam_vsync;
  logic [7:0]    cam_d;
  logic          wr_en, frame_done, capturing;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;

  always #5 clk = ~clk;

  ov7670_capture #(.H_ACT(H), .V_ACT(V), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_cap_en(cap_en), .i_cam_pclk(cam_pclk),
    .i_cam_href(cam_href), .i_cam_vsync(cam_vsync), .i_cam_d(cam_d),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_frame_done(frame_done), .o_capturing(capturing)
  );

  int n_chk = 0, n_err = 0;
  logic [31:0] got_q[$], exp_q[$];
  int done_cnt = 0, done_base = 0;
  int last_lat, line_lat, fd_lat;
  int m_row, m_col;
  bit m_arm;

  always @(negedge clk) begin
    if (wr_en) got_q.push_back({16'(wr_addr), 4'h0, wr_data});
    if (frame_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    cam_d = b;
    repeat (2) @(negedge clk);
    cam_pclk = 1'b1;
    last_lat = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (wr_en && last_lat == 0) last_lat = i;
    end
    cam_pclk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_pixel(input logic [7:0] b0, input logic [7:0] b1);
    int a;
    send_byte(b0);
    send_byte(b1);
    a = DEC ? (m_row / 2) * (H / 2) + m_col / 2 : m_row * H + m_col;
    if (m_arm && m_col < H && m_row < V && (!DEC || (m_row % 2 == 0 && m_col % 2 == 0)))
      exp_q.push_back({16'(a), 4'h0, b0[3:0], b1});
    m_col++;
  endtask

  task automatic send_line(input int npix, input bit extra, input bit fixed);
    int v;
    cam_href = 1'b1;
    repeat (3) @(negedge clk);
    for (int p = 0; p < npix; p++) begin
      v = m_row * 7 + p * 3 + 1;
      if (fixed) send_pixel(8'h0A, 8'hBC);
      else       send_pixel({4'hF, 4'(v)}, 8'(v * 37 + 5));
      if (p == 0) line_lat = last_lat;
    end
    if (extra) send_byte(8'h77);
    cam_href = 1'b0;
    repeat (6) @(negedge clk);
    m_row++;
    m_col = 0;
  endtask

  task automatic vsync_up();
    cam_vsync = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic start_frame(input string tag);
    m_arm = cap_en;
    m_row = 0;
    m_col = 0;
    cam_vsync = 1'b0;
    repeat (8) @(negedge clk);
    chk({tag, "_capturing"}, 32'(capturing), 32'(m_arm));
  endtask

  task automatic compare(input string tag, input int exp_done);
    chk({tag, "_nwr"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), got_q[i], exp_q[i]);
    chk({tag, "_done"}, done_cnt - done_base, exp_done);
    got_q.delete();
    exp_q.delete();
    done_base = done_cnt;
  endtask

  initial begin
    rst = 1'b0; cap_en = 1'b0; cam_pclk = 1'b0; cam_href = 1'b0; cam_vsync = 1'b0; cam_d = '0;
    m_arm = 1'b0; m_row = 0; m_col = 0;
    repeat (4) @(negedge clk);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_addr", 32'(wr_addr), 0);
    chk("rst_data", 32'(wr_data), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_capturing", 32'(capturing), 0);
    rst = 1'b1;
    cap_en = 1'b1;

    // F1: 4x2 frame of 0x0A,0xBC pixels
    vsync_up();
    start_frame("f1");
    send_line(4, 1'b0, 1'b1);
    chk("f1_latency", line_lat, 4);
    send_line(4, 1'b0, 1'b1);
    vsync_up();
    compare("f1", 1);

    // F2: 5 pixels plus a dangling byte, then rows past V_ACT
    start_frame("f2");
    send_line(5, 1'b1, 1'b0);
    for (int l = 0; l < 4; l++) send_line(4, 1'b0, 1'b0);
    vsync_up();
    compare("f2", 1);

    // F3: disarmed at frame start, cap_en raised mid-frame
    cap_en = 1'b0;
    start_frame("f3");
    cap_en = 1'b1;
    send_line(4, 1'b0, 1'b0);
    chk("f3_capturing_mid", 32'(capturing), 0);
    vsync_up();
    compare("f3", 0);

    // F4: next frame picks up the new cap_en
    start_frame("f4");
    send_line(4, 1'b0, 1'b0);
    vsync_up();
    compare("f4", 1);

    // F5: vsync rises together with the second byte of a pixel
    start_frame("f5");
    cam_href = 1'b1;
    repeat (3) @(negedge clk);
    send_pixel(8'h03, 8'h45);
    send_byte(8'h0C);
    cam_d = 8'hDE;
    repeat (2) @(negedge clk);
    cam_vsync = 1'b1;
    cam_pclk = 1'b1;
    fd_lat = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (frame_done && fd_lat == 0) fd_lat = i;
    end
    cam_pclk = 1'b0;
    cam_href = 1'b0;
    repeat (12) @(negedge clk);
    chk("f5_done_latency", fd_lat, 4);
    compare("f5", 1);

    // F6: reset mid-line with a pixel pending, vsync low
    start_frame("f6");
    cam_href = 1'b1;
    repeat (3) @(negedge clk);
    send_pixel(8'h01, 8'h23);
    send_byte(8'h0F);
    cam_d = 8'h99;
    repeat (2) @(negedge clk);
    cam_pclk = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("f6_rst_capturing", 32'(capturing), 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    cam_pclk = 1'b0;
    repeat (3) @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      send_byte(8'h0E);
      send_byte(8'hEE);
    end
    cam_href = 1'b0;
    repeat (6) @(negedge clk);
    compare("f6", 0);
    vsync_up();
    compare("f6_sync", 0);

    // F7: first full frame after the reset
    start_frame("f7");
    send_line(4, 1'b0, 1'b0);
    send_line(4, 1'b0, 1'b0);
    vsync_up();
    compare("f7", 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
